// File: rtl/code_stream_buffer.sv
// Show-ahead FIFO that buffers legal priority-decoder codes for a valid/ready consumer.
// It also keeps saturating accept/drop counters and a sticky illegal-code flag.
module code_stream_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 in_code,
  input  logic                       in_vld,
  output logic [2:0]                 out_code,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           acc_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [2:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic legal;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic illegal;

  // The decoder only ever produces these four codes; anything else is corruption.
  always_comb begin
    legal = 1'b0;
    case (in_code)
      3'b000, 3'b001, 3'b011, 3'b100: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
  end

  assign full      = (level == FULL_LVL);
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign push      = in_vld & legal & (~full | pop);
  assign drop      = in_vld & legal & full & ~pop;
  assign illegal   = in_vld & ~legal;
  assign out_code  = out_valid ? mem[rd_ptr] : 3'b000;

  // Storage has no reset; entries are only observable once level says so.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= in_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt  <= '0;
      drop_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (push && (acc_cnt != '1)) begin
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (illegal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_code_stream_buffer.sv
// Directed bench for code_stream_buffer: expected codes are queued as stimulus is issued
// and a negedge monitor compares them against every accepted output beat.
module tb_code_stream_buffer;

  logic       clk;
  logic       rst;
  logic [2:0] in_code;
  logic       in_vld;
  logic [2:0] out_code;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic [7:0] acc_cnt;
  logic [7:0] drop_cnt;
  logic       err;

  int vectors;
  int miscompares;
  logic [2:0] exp_q [$];

  code_stream_buffer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_code   (in_code),
    .in_vld    (in_vld),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .acc_cnt   (acc_cnt),
    .drop_cnt  (drop_cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every beat the consumer takes must match the oldest expected code.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got code %0d, expected no output", out_code);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (out_code !== e) begin
          miscompares++;
          $display("FAIL sb_code: got %0d, expected %0d", out_code, e);
        end
      end
    end
  end

  task automatic step(input logic vld, input logic [2:0] code, input logic rdy);
    in_vld    = vld;
    in_code   = code;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Reset with a legal push and a ready consumer pending, to show reset wins.
  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    in_vld    = 1'b1;
    in_code   = 3'b011;
    out_ready = 1'b1;
    exp_q.delete();
    repeat (cycles) @(posedge clk);
    #1;
    rst    = 1'b0;
    in_vld = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic fill4;
    step(1'b1, 3'b000, 1'b0); exp_q.push_back(3'b000);
    step(1'b1, 3'b001, 1'b0); exp_q.push_back(3'b001);
    step(1'b1, 3'b011, 1'b0); exp_q.push_back(3'b011);
    step(1'b1, 3'b100, 1'b0); exp_q.push_back(3'b100);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    in_vld      = 1'b0;
    in_code     = 3'b000;
    out_ready   = 1'b0;
    #2;

    // Reset state
    do_reset(2);
    check("rst_level", level, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_code", out_code, 0);
    check("rst_acc_cnt", acc_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_err", err, 0);

    // Latency and ordering with a ready consumer
    exp_q.push_back(3'b001);
    step(1'b1, 3'b001, 1'b1);
    check("lat_valid_c2", out_valid, 1);
    check("lat_code_c2", out_code, 3'b001);
    exp_q.push_back(3'b100);
    step(1'b1, 3'b100, 1'b1);
    check("lat_code_c3", out_code, 3'b100);
    step(1'b0, 3'b000, 1'b1);
    check("lat_valid_c4", out_valid, 0);
    check("lat_acc_cnt", acc_cnt, 2);

    // Overflow: fifth push with no pop is dropped
    do_reset(1);
    fill4();
    step(1'b1, 3'b011, 1'b0);
    check("ovf_level", level, 4);
    check("ovf_drop_cnt", drop_cnt, 1);
    check("ovf_acc_cnt", acc_cnt, 4);
    repeat (4) step(1'b0, 3'b000, 1'b1);
    check("ovf_drained_level", level, 0);
    check("ovf_sb_empty", exp_q.size(), 0);

    // Full with simultaneous push and pop
    do_reset(1);
    fill4();
    check("fpp_level_before", level, 4);
    exp_q.push_back(3'b011);
    step(1'b1, 3'b011, 1'b1);
    check("fpp_level", level, 4);
    check("fpp_drop_cnt", drop_cnt, 0);
    check("fpp_acc_cnt", acc_cnt, 5);
    repeat (4) step(1'b0, 3'b000, 1'b1);
    check("fpp_sb_empty", exp_q.size(), 0);
    check("fpp_out_valid", out_valid, 0);

    // Illegal code on an empty FIFO
    do_reset(1);
    step(1'b1, 3'b110, 1'b0);
    check("ill_err", err, 1);
    check("ill_level", level, 0);
    check("ill_acc_cnt", acc_cnt, 0);
    repeat (10) step(1'b0, 3'b000, 1'b0);
    check("ill_err_sticky", err, 1);
    step(1'b1, 3'b010, 1'b0);
    check("ill_010_level", level, 0);
    step(1'b1, 3'b101, 1'b0);
    step(1'b1, 3'b111, 1'b0);
    check("ill_all_level", level, 0);
    check("ill_all_drop_cnt", drop_cnt, 0);

    // Drop-counter saturation, then reset mid-operation
    do_reset(1);
    fill4();
    repeat (300) step(1'b1, 3'b001, 1'b0);
    check("sat_drop_cnt", drop_cnt, 255);
    check("sat_acc_cnt", acc_cnt, 4);
    check("sat_level", level, 4);
    step(1'b0, 3'b000, 1'b1);
    check("sat_level_3", level, 3);
    do_reset(1);
    check("mid_rst_level", level, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_code", out_code, 0);
    check("mid_rst_acc_cnt", acc_cnt, 0);
    check("mid_rst_drop_cnt", drop_cnt, 0);
    check("mid_rst_err", err, 0);
    exp_q.push_back(3'b100);
    step(1'b1, 3'b100, 1'b0);
    check("post_rst_code", out_code, 3'b100);
    check("post_rst_level", level, 1);
    step(1'b0, 3'b000, 1'b1);
    check("post_rst_drained", out_valid, 0);
    check("post_rst_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
